// File: rtl/book_update_arbiter_pkg.sv
// Shared types and constants for the book update arbiter: message and
// book-level layouts, field offsets and the legal action / entry codes.
package book_update_arbiter_pkg;

  localparam int MSG_W   = 176;
  localparam int LEVEL_W = 128;

  // Bit offsets of each field inside the 176-bit message (MSB first layout).
  localparam int PRICE_LSB  = 0;
  localparam int QTY_LSB    = 64;
  localparam int NORD_LSB   = 96;
  localparam int ETYPE_LSB  = 128;
  localparam int ACTION_LSB = 136;
  localparam int SECID_LSB  = 144;

  // Requester indices shared by the arbiter and the top level.
  localparam int REQ_PARSER = 0;
  localparam int REQ_HOST   = 1;

  typedef enum logic [7:0] {
    ACT_NEW    = 8'd0,
    ACT_CHANGE = 8'd1,
    ACT_DELETE = 8'd2
  } action_e;

  typedef enum logic [7:0] {
    ENTRY_BID = 8'd0,
    ENTRY_ASK = 8'd1
  } entry_e;

  // Action and entry type stay raw bytes: illegal codes must be representable.
  typedef struct packed {
    logic [31:0] security_id;
    logic [7:0]  action;
    logic [7:0]  entry_type;
    logic [31:0] num_orders;
    logic [31:0] quantity;
    logic [63:0] price;
  } msg_t;

  typedef struct packed {
    logic [31:0] num_orders;
    logic [31:0] quantity;
    logic [63:0] price;
  } level_t;

  // A message is forwarded only if both codes are ones the order book knows.
  function automatic logic msg_legal(input msg_t m);
    logic [MSG_W-1:0] raw;
    raw = m;
    return (raw[ACTION_LSB +: 8] <= ACT_DELETE) && (raw[ETYPE_LSB +: 8] <= ENTRY_ASK);
  endfunction

endpackage

// File: rtl/book_update_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: a lone requester always wins, on a tie
// the pointer decides (0 = parser, 1 = host). Purely combinational.
module rr_arb2
  import book_update_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // One-hot grant selection from request pattern and pointer.
  always_comb begin
    // NOTE: grant gets a default first so no latch is inferred on any path.
    grant = 2'b00;
    case (req)
      2'b01:   grant[REQ_PARSER] = 1'b1;
      2'b10:   grant[REQ_HOST]   = 1'b1;
      2'b11: begin
        if (ptr) grant[REQ_HOST]   = 1'b1;
        else     grant[REQ_PARSER] = 1'b1;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/book_update_arbiter.sv
// Arbitrates parser and host updates into the order book, strobes each legal
// update, waits for the book to settle and captures a top-of-book snapshot.
module book_update_arbiter
  import book_update_arbiter_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int SEQ_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             p_valid,
  output logic             p_ready,
  input  msg_t             p_msg,
  input  logic             h_valid,
  output logic             h_ready,
  input  msg_t             h_msg,
  output logic             ob_message_ready,
  output msg_t             ob_msg,
  input  level_t           best_bid,
  input  level_t           best_ask,
  output logic             snap_valid,
  output level_t           snap_bid,
  output level_t           snap_ask,
  output logic [SEQ_W-1:0] snap_seq,
  output logic [SEQ_W-1:0] msg_count,
  output logic [SEQ_W-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, CAPTURE} state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  msg_t             ob_msg_q, ob_msg_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic             snap_valid_q, snap_valid_d;
  level_t           snap_bid_q, snap_bid_d;
  level_t           snap_ask_q, snap_ask_d;
  logic [SEQ_W-1:0] snap_seq_q, snap_seq_d;
  logic [SEQ_W-1:0] msg_count_q, msg_count_d;
  logic [SEQ_W-1:0] drop_count_q, drop_count_d;

  logic [1:0] arb_grant;
  logic       grant_ok;
  logic       issue_strobe;

  rr_arb2 u_arb (
    .req   ({h_valid, p_valid}),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  // Handshakes only open in IDLE with enable high and never while in reset.
  assign grant_ok = (state_q == IDLE) && enable && !reset;
  assign p_ready  = grant_ok && arb_grant[REQ_PARSER];
  assign h_ready  = grant_ok && arb_grant[REQ_HOST];

  // Next-state and datapath updates for the grant / issue / settle / capture cycle.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ob_msg_d     = ob_msg_q;
    settle_cnt_d = settle_cnt_q;
    snap_valid_d = 1'b0;
    snap_bid_d   = snap_bid_q;
    snap_ask_d   = snap_ask_q;
    snap_seq_d   = snap_seq_q;
    msg_count_d  = msg_count_q;
    drop_count_d = drop_count_q;
    issue_strobe = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ok && (arb_grant != 2'b00)) begin
          ob_msg_d = arb_grant[REQ_HOST] ? h_msg : p_msg;
          ptr_d    = ~ptr_q;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (msg_legal(ob_msg_q)) begin
          issue_strobe = 1'b1;
          msg_count_d  = msg_count_q + 1'b1;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = SETTLE;
        end else begin
          drop_count_d = drop_count_q + 1'b1;
          state_d      = IDLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == 4'd0) state_d = CAPTURE;
        else                      settle_cnt_d = settle_cnt_q - 4'd1;
      end
      CAPTURE: begin
        snap_bid_d   = best_bid;
        snap_ask_d   = best_ask;
        snap_valid_d = 1'b1;
        snap_seq_d   = snap_seq_q + 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      ob_msg_q     <= '0;
      settle_cnt_q <= '0;
      snap_valid_q <= 1'b0;
      snap_bid_q   <= '0;
      snap_ask_q   <= '0;
      snap_seq_q   <= '0;
      msg_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ob_msg_q     <= ob_msg_d;
      settle_cnt_q <= settle_cnt_d;
      snap_valid_q <= snap_valid_d;
      snap_bid_q   <= snap_bid_d;
      snap_ask_q   <= snap_ask_d;
      snap_seq_q   <= snap_seq_d;
      msg_count_q  <= msg_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign ob_message_ready = issue_strobe && !reset;
  assign ob_msg           = ob_msg_q;
  assign snap_valid       = snap_valid_q;
  assign snap_bid         = snap_bid_q;
  assign snap_ask         = snap_ask_q;
  assign snap_seq         = snap_seq_q;
  assign msg_count        = msg_count_q;
  assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_book_update_arbiter.sv
// Scoreboard bench for book_update_arbiter: grants, strobes and snapshots are
// predicted when stimulus is granted and matched as the DUT produces them.
module tb_book_update_arbiter;
  import book_update_arbiter_pkg::*;

  localparam int SEQ_W = 16;
  localparam int S1    = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with default settle time.
  logic             enable, p_valid, h_valid, p_ready, h_ready;
  msg_t             p_msg, h_msg, ob_msg;
  logic             ob_message_ready, snap_valid;
  level_t           best_bid, best_ask, snap_bid, snap_ask;
  logic [SEQ_W-1:0] snap_seq, msg_count, drop_count;

  book_update_arbiter #(.SETTLE_CYCLES(S1), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .p_valid(p_valid), .p_ready(p_ready), .p_msg(p_msg),
    .h_valid(h_valid), .h_ready(h_ready), .h_msg(h_msg),
    .ob_message_ready(ob_message_ready), .ob_msg(ob_msg),
    .best_bid(best_bid), .best_ask(best_ask),
    .snap_valid(snap_valid), .snap_bid(snap_bid), .snap_ask(snap_ask),
    .snap_seq(snap_seq), .msg_count(msg_count), .drop_count(drop_count)
  );

  // DUT with a three-cycle settle time.
  logic             p3_valid, p3_ready, h3_ready;
  msg_t             p3_msg, ob3_msg;
  logic             ob3_ready, snap3_valid;
  level_t           best3_bid, snap3_bid, snap3_ask;
  logic [SEQ_W-1:0] snap3_seq, msg3_count, drop3_count;

  book_update_arbiter #(.SETTLE_CYCLES(3), .SEQ_W(SEQ_W)) dut3 (
    .clk(clk), .reset(reset), .enable(1'b1),
    .p_valid(p3_valid), .p_ready(p3_ready), .p_msg(p3_msg),
    .h_valid(1'b0), .h_ready(h3_ready), .h_msg('0),
    .ob_message_ready(ob3_ready), .ob_msg(ob3_msg),
    .best_bid(best3_bid), .best_ask('0),
    .snap_valid(snap3_valid), .snap_bid(snap3_bid), .snap_ask(snap3_ask),
    .snap_seq(snap3_seq), .msg_count(msg3_count), .drop_count(drop3_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic msg_t mk_msg(input int sec, input int act, input int et,
                                  input int nord, input int qty, input longint price);
    msg_t m;
    m.security_id = 32'(sec);
    m.action      = 8'(act);
    m.entry_type  = 8'(et);
    m.num_orders  = 32'(nord);
    m.quantity    = 32'(qty);
    m.price       = 64'(price);
    return m;
  endfunction

  function automatic bit legal(input msg_t m);
    return (m.action < 8'd3) && (m.entry_type < 8'd2);
  endfunction

  typedef struct { bit host; int gap; } grant_exp_t;
  typedef struct { int cyc; msg_t msg; } strobe_exp_t;
  typedef struct { int cyc; logic [SEQ_W-1:0] seq; } snap_exp_t;

  grant_exp_t  exp_grant_q[$];
  strobe_exp_t exp_strobe_q[$];
  snap_exp_t   exp_snap_q[$];

  int               n_grants = 0;
  int               last_grant_cyc = 0;
  int               m_msg = 0, m_drop = 0;
  logic [SEQ_W-1:0] m_seq = '0;
  msg_t             held_msg = '0;
  level_t           prev_bid = '0, prev_ask = '0;

  // Monitor: match DUT events against predictions and create new predictions.
  always @(negedge clk) begin
    if (reset) begin
      exp_grant_q.delete();
      exp_strobe_q.delete();
      exp_snap_q.delete();
      m_msg = 0; m_drop = 0; m_seq = '0; held_msg = '0;
    end else begin
      if (ob_msg !== held_msg) check("ob_msg_stable", 256'(ob_msg), 256'(held_msg));

      if (p_ready || h_ready) begin
        grant_exp_t g;
        msg_t       m;
        m = h_ready ? h_msg : p_msg;
        n_grants++;
        if (exp_grant_q.size() == 0) begin
          check("unexpected_grant", 256'(exp_grant_q.size()), 256'(1));
        end else begin
          g = exp_grant_q.pop_front();
          check("grant_src", 256'({p_ready, h_ready}), g.host ? 256'(2'b01) : 256'(2'b10));
          if (g.gap != 0) check("grant_gap", 256'(cyc - last_grant_cyc), 256'(g.gap));
        end
        last_grant_cyc = cyc;
        held_msg = m;
        if (legal(m)) begin
          m_msg++;
          m_seq++;
          exp_strobe_q.push_back('{cyc: cyc + 1, msg: m});
          exp_snap_q.push_back('{cyc: cyc + 3 + S1, seq: m_seq});
        end else begin
          m_drop++;
        end
      end

      if (ob_message_ready) begin
        if (exp_strobe_q.size() == 0) begin
          check("unexpected_strobe", 256'(exp_strobe_q.size()), 256'(1));
        end else begin
          strobe_exp_t s;
          s = exp_strobe_q.pop_front();
          check("strobe_cycle", 256'(cyc), 256'(s.cyc));
          check("strobe_msg", 256'(ob_msg), 256'(s.msg));
        end
      end
      if (exp_strobe_q.size() > 0 && exp_strobe_q[0].cyc < cyc) begin
        check("strobe_missed", 256'(cyc), 256'(exp_strobe_q[0].cyc));
        void'(exp_strobe_q.pop_front());
      end

      if (snap_valid) begin
        if (exp_snap_q.size() == 0) begin
          check("unexpected_snap", 256'(exp_snap_q.size()), 256'(1));
        end else begin
          snap_exp_t e;
          e = exp_snap_q.pop_front();
          check("snap_cycle", 256'(cyc), 256'(e.cyc));
          check("snap_seq", 256'(snap_seq), 256'(e.seq));
          check("snap_bid", 256'(snap_bid), 256'(prev_bid));
          check("snap_ask", 256'(snap_ask), 256'(prev_ask));
        end
      end
      if (exp_snap_q.size() > 0 && exp_snap_q[0].cyc < cyc) begin
        check("snap_missed", 256'(cyc), 256'(exp_snap_q[0].cyc));
        void'(exp_snap_q.pop_front());
      end
    end
    prev_bid = best_bid;
    prev_ask = best_ask;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a ready on the chosen port, then step into the next cycle.
  task automatic wait_grant(input bit host, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (host ? h_ready : p_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check({tag, "_timeout"}, 256'(got), 256'(1));
    tick();
  endtask

  task automatic drain(input string tag);
    repeat (10) tick();
    check({tag, "_strobes_left"}, 256'(exp_strobe_q.size()), 256'(0));
    check({tag, "_snaps_left"}, 256'(exp_snap_q.size()), 256'(0));
    check({tag, "_msg_count"}, 256'(msg_count), 256'(m_msg));
    check({tag, "_drop_count"}, 256'(drop_count), 256'(m_drop));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g3, cnt;
    bit seen;
    reset = 1'b1; enable = 1'b1;
    p_valid = 1'b1; h_valid = 1'b1;
    p_msg = mk_msg(1, 0, 0, 1, 1, 1); h_msg = p_msg;
    best_bid = '0; best_ask = '0;
    p3_valid = 1'b0; p3_msg = '0; best3_bid = '0;
    tick(); tick();

    // Reset state, with both requesters asserting valid.
    check("rst_p_ready", 256'(p_ready), 256'(0));
    check("rst_h_ready", 256'(h_ready), 256'(0));
    check("rst_strobe", 256'(ob_message_ready), 256'(0));
    check("rst_snap_valid", 256'(snap_valid), 256'(0));
    check("rst_ob_msg", 256'(ob_msg), 256'(0));
    check("rst_snap_bid", 256'(snap_bid), 256'(0));
    check("rst_counters", 256'({snap_seq, msg_count, drop_count}), 256'(0));
    p_valid = 1'b0; h_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Parser-only NEW bid, price 12 qty 5.
    best_bid = '{num_orders: 32'd2, quantity: 32'd5, price: 64'd12};
    best_ask = '{num_orders: 32'd1, quantity: 32'd7, price: 64'd14};
    exp_grant_q.push_back('{host: 1'b0, gap: 0});
    p_msg = mk_msg(100, ACT_NEW, ENTRY_BID, 1, 5, 12);
    p_valid = 1'b1;
    wait_grant(1'b0, "t1");
    p_valid = 1'b0;
    drain("t1");
    check("t1_snap_seq", 256'(snap_seq), 256'(1));

    // Contention: both valid for four transactions, grants alternate.
    do_reset();
    exp_grant_q.push_back('{host: 1'b0, gap: 0});
    exp_grant_q.push_back('{host: 1'b1, gap: 3 + S1});
    exp_grant_q.push_back('{host: 1'b0, gap: 3 + S1});
    exp_grant_q.push_back('{host: 1'b1, gap: 3 + S1});
    p_msg = mk_msg(200, ACT_CHANGE, ENTRY_ASK, 3, 40, 1001);
    h_msg = mk_msg(201, ACT_DELETE, ENTRY_BID, 0, 0, 999);
    base = n_grants;
    p_valid = 1'b1; h_valid = 1'b1;
    for (int i = 0; i < 100 && n_grants < base + 4; i++) @(posedge clk);
    check("t2_grant_count", 256'(n_grants - base), 256'(4));
    #1;
    p_valid = 1'b0; h_valid = 1'b0;
    drain("t2");
    check("t2_msg_count_4", 256'(msg_count), 256'(4));

    // Illegal host action is dropped; the next grant follows two cycles later.
    do_reset();
    exp_grant_q.push_back('{host: 1'b1, gap: 0});
    exp_grant_q.push_back('{host: 1'b0, gap: 2});
    h_msg = mk_msg(300, 5, ENTRY_BID, 1, 1, 50);
    h_valid = 1'b1;
    wait_grant(1'b1, "t3h");
    h_valid = 1'b0;
    p_msg = mk_msg(301, ACT_NEW, ENTRY_ASK, 2, 9, 77);
    p_valid = 1'b1;
    wait_grant(1'b0, "t3p");
    p_valid = 1'b0;
    drain("t3");
    check("t3_drop_count_1", 256'(drop_count), 256'(1));

    // enable low blocks grants; dropping it after a grant does not abort.
    do_reset();
    enable = 1'b0;
    p_valid = 1'b1; h_valid = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (p_ready || h_ready) cnt++;
    end
    check("t4_ready_while_disabled", 256'(cnt), 256'(0));
    tick();
    exp_grant_q.push_back('{host: 1'b0, gap: 0});
    enable = 1'b1;
    wait_grant(1'b0, "t4");
    enable = 1'b0;
    p_valid = 1'b0; h_valid = 1'b0;
    drain("t4");
    check("t4_snap_seq", 256'(snap_seq), 256'(1));
    enable = 1'b1;

    // Reset during SETTLE discards the transaction.
    do_reset();
    exp_grant_q.push_back('{host: 1'b0, gap: 0});
    p_msg = mk_msg(500, ACT_NEW, ENTRY_BID, 4, 8, 123);
    p_valid = 1'b1;
    wait_grant(1'b0, "t5a");
    p_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    repeat (8) tick();
    check("t5_counters_zero", 256'({snap_seq, msg_count, drop_count}), 256'(0));
    exp_grant_q.push_back('{host: 1'b0, gap: 0});
    p_valid = 1'b1;
    wait_grant(1'b0, "t5b");
    p_valid = 1'b0;
    drain("t5");
    check("t5_snap_seq", 256'(snap_seq), 256'(1));

    // SETTLE_CYCLES=3: snapshot at grant+6 captures the value set during SETTLE.
    do_reset();
    best3_bid = '{num_orders: 32'd1, quantity: 32'd1, price: 64'd10};
    p3_msg = mk_msg(600, ACT_NEW, ENTRY_BID, 1, 2, 20);
    p3_valid = 1'b1;
    g3 = -1;
    for (int i = 0; i < 50 && g3 < 0; i++) begin
      @(negedge clk);
      if (p3_ready) g3 = cyc;
    end
    check("t6_grant_seen", 256'(g3 >= 0), 256'(1));
    tick();
    p3_valid = 1'b0;
    tick();
    best3_bid = '{num_orders: 32'd6, quantity: 32'd60, price: 64'd600};
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (snap3_valid) begin
        seen = 1'b1;
        check("t6_snap_cycle", 256'(cyc - g3), 256'(6));
        check("t6_snap_bid", 256'(snap3_bid), 256'({32'd6, 32'd60, 64'd600}));
        check("t6_snap_seq", 256'(snap3_seq), 256'(1));
      end
    end
    check("t6_snap_seen", 256'(seen), 256'(1));
    check("t6_msg_count", 256'(msg3_count), 256'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
